// File: rtl/nibble_alu_sequencer_if.sv
// Bundle of request, response and shared-ALU signals between the central unit,
// the nibble sequencer and the 4-bit ALU.
interface nibble_alu_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   op_s;
  logic         op_m;
  logic         op_cin;

  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_pin;
  logic [3:0]   alu_r;
  logic [3:0]   alu_p;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         cout;
  logic         zero;

  modport master (
    output in_valid, op_a, op_b, op_s, op_m, op_cin, out_ready, alu_r, alu_p,
    input  in_ready, out_valid, res, cout, zero, alu_a, alu_b, alu_s, alu_m, alu_pin
  );

  modport slave (
    input  in_valid, op_a, op_b, op_s, op_m, op_cin, out_ready, alu_r, alu_p,
    output in_ready, out_valid, res, cout, zero, alu_a, alu_b, alu_s, alu_m, alu_pin
  );
endinterface

// File: rtl/nibble_alu_sequencer.sv
// Runs a wide operand pair through a shared 4-bit ALU one nibble per clock,
// LSB first, rippling the ALU carry between nibbles.
module nibble_alu_sequencer #(
  parameter int NIBBLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  nibble_alu_sequencer_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [KW-1:0] k_q;
  logic [W-1:0]  a_q, b_q, res_q, res_d;
  logic [3:0]    s_q;
  logic          m_q, cin_q, carry_q, cout_q;

  logic [3:0]    drv_a, drv_b, drv_s;
  logic          drv_m, drv_pin;

  // ALU is driven only while RUN so the shared instance stays quiet otherwise.
  always_comb begin
    drv_a   = 4'd0;
    drv_b   = 4'd0;
    drv_s   = 4'd0;
    drv_m   = 1'b0;
    drv_pin = 1'b0;
    res_d   = res_q;
    if (state_q == RUN) begin
      drv_s   = s_q;
      drv_m   = m_q;
      drv_pin = (k_q == '0) ? cin_q : carry_q;
      for (int i = 0; i < NIBBLES; i++) begin
        if (k_q == KW'(i)) begin
          drv_a             = a_q[4*i +: 4];
          drv_b             = b_q[4*i +: 4];
          res_d[4*i +: 4]   = bus.alu_r;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 4'd0;
      m_q     <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            s_q     <= bus.op_s;
            m_q     <= bus.op_m;
            cin_q   <= bus.op_cin;
            k_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= bus.alu_p[3];
          // Index parks on the last nibble rather than wrapping.
          if (k_q == LAST_K) begin
            cout_q  <= bus.alu_p[3];
            state_q <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a     = drv_a;
  assign bus.alu_b     = drv_b;
  assign bus.alu_s     = drv_s;
  assign bus.alu_m     = drv_m;
  assign bus.alu_pin   = drv_pin;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res       = res_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = (res_q == '0);
endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Directed bench for nibble_alu_sequencer with a behavioural 4-bit ALU
// (add for M=0, xor for M=1).
module tb_nibble_alu_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  nibble_alu_sequencer_if #(.NIBBLES(4)) bus ();

  nibble_alu_sequencer #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU model
  always_comb begin
    logic [4:0] sum;
    sum = 5'(bus.alu_a) + 5'(bus.alu_b) + 5'(bus.alu_pin);
    if (bus.alu_m) begin
      bus.alu_r = bus.alu_a ^ bus.alu_b;
      bus.alu_p = 4'd0;
    end else begin
      bus.alu_r = sum[3:0];
      bus.alu_p = {sum[4], 3'b000};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns in the first RUN cycle (k=0).
  task automatic start(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] s, input logic m, input logic cin);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_s     = s;
    bus.op_m     = m;
    bus.op_cin   = cin;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.op_a     = 16'h0;
    bus.op_b     = 16'h0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_res"},       32'(bus.res),       32'd0);
    chk({tag, "_cout"},      32'(bus.cout),      32'd0);
    chk({tag, "_zero"},      32'(bus.zero),      32'd1);
    chk({tag, "_alu_drv"},   32'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_pin}), 32'd0);
  endtask

  initial begin
    logic [3:0] pins;
    logic       seen, bad;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = 16'h0;
    bus.op_b      = 16'h0;
    bus.op_s      = 4'h0;
    bus.op_m      = 1'b0;
    bus.op_cin    = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    step();

    // Reset during the second RUN cycle
    start(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    chk("run_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrun_rst");
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= bus.out_valid;
    end
    chk("no_valid_after_rst", 32'(seen), 32'd0);

    // Add with ripple carry
    start(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    pins = 4'h0;
    for (int i = 0; i < 4; i++) begin
      pins[i] = bus.alu_pin;
      if (i == 3) chk("add_no_early_valid", 32'(bus.out_valid), 32'd0);
      step();
    end
    chk("add_pin_seq",   32'(pins),          32'h6);
    chk("add_out_valid", 32'(bus.out_valid), 32'd1);
    chk("add_res",       32'(bus.res),       32'h0100);
    chk("add_cout",      32'(bus.cout),      32'd0);
    chk("add_zero",      32'(bus.zero),      32'd0);
    chk("add_alu_quiet", 32'({bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_pin}), 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("add_idle_ready", 32'(bus.in_ready),  32'd1);
    chk("add_idle_valid", 32'(bus.out_valid), 32'd0);

    // Overflow to zero, consumer already ready
    bus.out_ready = 1'b1;
    start(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("ovf_out_valid", 32'(bus.out_valid), 32'd1);
    chk("ovf_res",       32'(bus.res),       32'h0000);
    chk("ovf_cout",      32'(bus.cout),      32'd1);
    chk("ovf_zero",      32'(bus.zero),      32'd1);
    step();
    bus.out_ready = 1'b0;
    chk("ovf_done_1cyc", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    // Backpressure with an ignored in_valid pulse
    start(16'h9234, 16'h8111, 4'b1001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.op_a     = 16'h0001;
        bus.op_b     = 16'h0001;
        bus.in_valid = 1'b1;
      end
      if (i == 4) bus.in_valid = 1'b0;
      if (bus.out_valid !== 1'b1 || bus.res !== 16'h1345 || bus.cout !== 1'b1 ||
          bus.in_ready !== 1'b0) bad = 1'b1;
      step();
    end
    chk("bp_stable",  32'(bad),      32'd0);
    chk("bp_res",     32'(bus.res),  32'h1345);
    chk("bp_cout",    32'(bus.cout), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_release", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    step();
    chk("bp_pulse_ignored", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    // Logic mode: xor
    start(16'hA5A5, 16'hFFFF, 4'b0110, 1'b1, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.alu_m !== 1'b1 || bus.alu_s !== 4'b0110) bad = 1'b1;
      step();
    end
    chk("logic_drive", 32'(bad),           32'd0);
    chk("logic_valid", 32'(bus.out_valid), 32'd1);
    chk("logic_res",   32'(bus.res),       32'h5A5A);
    chk("logic_zero",  32'(bus.zero),      32'd0);
    chk("logic_cout",  32'(bus.cout),      32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("logic_idle", 32'(bus.in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
